// File: rtl/cond_pkg.sv
// Shared definitions for the Execute-stage condition unit.
// Contents: condition-code enum (EQ..AL, NV), NZCV flag bit indices,
// packed flag struct, and the condition-pass evaluation function.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic cond_pass(input logic [3:0] cond, input flags_t f);
    logic pass;
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = f.z;
      COND_NE: pass = ~f.z;
      COND_CS: pass = f.c;
      COND_CC: pass = ~f.c;
      COND_MI: pass = f.n;
      COND_PL: pass = ~f.n;
      COND_VS: pass = f.v;
      COND_VC: pass = ~f.v;
      COND_HI: pass = f.c & ~f.z;
      COND_LS: pass = ~f.c | f.z;
      COND_GE: pass = (f.n == f.v);
      COND_LT: pass = (f.n != f.v);
      COND_GT: pass = ~f.z & (f.n == f.v);
      COND_LE: pass = f.z | (f.n != f.v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/flag_ckpt_fifo.sv
// Checkpoint FIFO of 4-bit flag snapshots.
// Ports: clk, reset (async, active-low), push/commit requests, clear
// (accepted restore, empties the FIFO), wdata (snapshot to enqueue),
// rdata (oldest entry), count, full, empty.
// A push is accepted when there is room or a commit frees a slot in the
// same cycle; a commit is accepted only when non-empty. Clear overrides both.
module flag_ckpt_fifo import cond_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       commit,
  input  logic                       clear,
  input  logic [3:0]                 wdata,
  output logic [3:0]                 rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_acc, commit_acc;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign push_acc   = push & ~clear & (~full | commit);
  assign commit_acc = commit & ~clear & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // On push+commit while full, wr_ptr == rd_ptr: the new entry lands in
      // the slot of the oldest one, which is being retired this same cycle.
      if (push_acc) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (commit_acc) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_acc) - CW'(commit_acc);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cond_unit_ckpt.sv
// Execute-stage condition unit with flag checkpoints for branch speculation.
// Holds architectural NZCV flags, evaluates CondE combinationally against
// the registered flags, applies per-group gated ALU flag writes, and keeps a
// FIFO of flag snapshots that can be committed or restored.
// Ports: clk, reset (async, active-low), FlagWriteE[NGRP], CondE, ALUFlags,
// CkptPushE/CkptCommitE/CkptRestoreE, Flags, CondExE, CkptCount,
// CkptFull, CkptEmpty, CkptErr.
// Optional build macro: COND_UNIT_ERR_EN enables the sticky CkptErr flag;
// without it CkptErr is tied low.
module cond_unit_ckpt import cond_pkg::*; #(
  parameter int NGRP  = 2,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NGRP-1:0]         FlagWriteE,
  input  logic [3:0]              CondE,
  input  logic [3:0]              ALUFlags,
  input  logic                    CkptPushE,
  input  logic                    CkptCommitE,
  input  logic                    CkptRestoreE,
  output logic [3:0]              Flags,
  output logic                    CondExE,
  output logic [$clog2(DEPTH):0]  CkptCount,
  output logic                    CkptFull,
  output logic                    CkptEmpty,
  output logic                    CkptErr
);

  localparam int GW = 4 / NGRP;

  logic [3:0] flags_q, flags_d;
  logic [3:0] wr_mask;
  logic [3:0] gated_flags;
  logic [3:0] ckpt_rdata;
  logic       restore_acc;

  always_comb begin
    wr_mask = '0;
    for (int g = 0; g < NGRP; g++) begin
      if (FlagWriteE[g]) begin
        for (int b = 0; b < GW; b++) wr_mask[g*GW + b] = 1'b1;
      end
    end
  end

  assign CondExE     = cond_pass(CondE, flags_t'(flags_q));
  assign gated_flags = CondExE ? ((ALUFlags & wr_mask) | (flags_q & ~wr_mask)) : flags_q;

  // A restore with nothing saved is dropped entirely, so the normal write path applies.
  assign restore_acc = CkptRestoreE & ~CkptEmpty;

  always_comb begin
    flags_d = gated_flags;
    if (restore_acc) flags_d = ckpt_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign Flags = flags_q;

  flag_ckpt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (CkptPushE),
    .commit (CkptCommitE),
    .clear  (restore_acc),
    .wdata  (gated_flags),
    .rdata  (ckpt_rdata),
    .count  (CkptCount),
    .full   (CkptFull),
    .empty  (CkptEmpty)
  );

`ifdef COND_UNIT_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | (CkptPushE & CkptFull & ~CkptCommitE & ~restore_acc)
          | (CkptCommitE & CkptEmpty)
          | (CkptRestoreE & CkptEmpty);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign CkptErr = err_q;
`else
  assign CkptErr = 1'b0;
`endif

endmodule

// File: doc/cond_unit_ckpt.md
# cond_unit_ckpt

Parametrised successor to the pipeline condition unit: holds the architectural NZCV flags, evaluates the Execute-stage condition code, and writes ALU flags per enable group when the instruction executes. It adds a FIFO of flag checkpoints so that speculation past predicted branches can be rolled back. It sits in the Execute stage beside the ALU, driven by the hazard/branch unit.

## Interface
- NGRP, 2: flag write-enable groups; 1, 2 or 4. Group g covers Flags[(g+1)*4/NGRP-1 : g*4/NGRP].
- DEPTH, 4: checkpoint FIFO depth; power of two, ≥2.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- FlagWriteE  in  NGRP  per-group flag write request.
- CondE  in  4  ARM condition code.
- ALUFlags  in  4  {N,Z,C,V} from ALU.
- CkptPushE  in  1  save flags for a newly predicted branch.
- CkptCommitE  in  1  oldest branch resolved correct; drop oldest checkpoint.
- CkptRestoreE  in  1  oldest branch mispredicted; roll back.
- Flags  out  4  architectural flags {N,Z,C,V}.
- CondExE  out  1  condition passes.
- CkptCount  out  $clog2(DEPTH)+1  valid checkpoints.
- CkptFull, CkptEmpty  out  1  FIFO status.
- CkptErr  out  1  sticky misuse flag (only with COND_UNIT_ERR_EN).

## Operation
- CondExE combinational from CondE and the Flags register: 0 EQ Z, 1 NE !Z, 2 CS C, 3 CC !C, 4 MI N, 5 PL !N, 6 VS V, 7 VC !V, 8 HI C&!Z, 9 LS !C|Z, 10 GE N==V, 11 LT N!=V, 12 GT !Z&(N==V), 13 LE Z|(N!=V), 14 AL 1, 15 → 0.
- Gated write: group g updates when FlagWriteE[g] & CondExE; other groups hold.
- Push: enqueues next-state flags, i.e. the value after this cycle's gated write.
- Commit: dequeues the oldest entry; Flags unchanged.
- Restore: Flags ← oldest entry; FIFO cleared (count 0); FlagWriteE, Push and Commit ignored that cycle.
- Priority: Restore > {Push, Commit}. Push+Commit together: both take effect, count unchanged; allowed when full.
- Push when full without Commit: dropped. Commit or Restore when empty: dropped; Restore also leaves Flags untouched (gated write still applies).
- Count arithmetic: count + push_acc − commit_acc; pointers wrap modulo DEPTH.

## Timing
- Reset (reset=0, async): Flags=0, count=0, pointers=0, CkptEmpty=1, CkptFull=0, CkptErr=0. CondExE then reflects Flags=0 (EQ fails, NE passes).
- Flags, count and status update on the rising clk edge after the request; one-cycle latency.
- CondExE zero latency; it sees the pre-write Flags of the current cycle (no same-cycle forwarding).
- Reset asserted mid-speculation discards all checkpoints immediately.

## Configuration
- COND_UNIT_ERR_EN defined: CkptErr sets on a dropped Push (full), dropped Commit or Restore (empty). It stays set until reset.
- Undefined: CkptErr port is tied to 0 and no error logic is built; drop behaviour is identical.

## Structure
- Shared package cond_pkg: condition-code enum (EQ…AL, NV), flag bit indices N=3, Z=2, C=1, V=0, and the flag struct type.
- One sub-module, flag_ckpt_fifo: DEPTH×4 storage, read/write pointers, count, full/empty, and restore-clear.
- condcheck logic lives inline or in a cond_pkg function.

## Test plan
- Reset, then FlagWriteE=2'b11, CondE=AL, ALUFlags=4'b0100 → next cycle Flags=4'b0100; CondE=EQ gives CondExE=1.
- Flags=4'b0100, CondE=NE, FlagWriteE=2'b11, ALUFlags=4'b1000 → CondExE=0; Flags stay 4'b0100.
- NGRP=2, FlagWriteE=2'b01, ALUFlags=4'b1111 from Flags=0 → Flags=4'b0011.
- Push with Flags=4'b0010 and a same-cycle write of 4'b1000 (AL, 2'b11), then two writes, then Restore → Flags=4'b1000, CkptCount=0, CkptEmpty=1.
- DEPTH=4: 4 pushes → CkptFull=1; 5th push dropped (CkptErr=1 if enabled); Push+Commit while full → count stays 4, FIFO order preserved on later Restore.
- Assert reset with 3 checkpoints → count=0 and Flags=0 immediately, without a clock edge.
